// File: rtl/ahb_pkg.sv
// ahb_pkg: shared AHB-Lite encodings and pipeline occupancy states
package ahb_pkg;
  localparam logic [1:0] HTRANS_IDLE = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic HSIZE_BYTE = 1'b0;
  localparam logic HSIZE_HALF = 1'b1;
  localparam logic HRESP_OKAY = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;
  typedef enum logic [1:0] {OCC_IDLE, OCC_ADDR, OCC_PIPE, OCC_DATA} occ_state_t;
endpackage

// File: rtl/ahb_lane_steer.sv
// ahb_lane_steer: byte-lane placement for writes or right-justification for reads
module ahb_lane_steer
  import ahb_pkg::*;
#(
  parameter bit EXTRACT = 1'b0
) (
  input  logic        size,
  input  logic        addr0,
  input  logic [15:0] din,
  output logic [15:0] dout
);
  // halfwords pass through; a byte moves between lane 0 and the lane chosen by addr0
  always_comb
    dout = size == HSIZE_HALF ? din :
           EXTRACT ? {8'h00, addr0 ? din[15:8] : din[7:0]} :
           addr0 ? {din[7:0], 8'h00} : {8'h00, din[7:0]};
endmodule

// File: rtl/ahb_lite_master.sv
// ahb_lite_master: command stream to pipelined single NONSEQ AHB-Lite transfers
module ahb_lite_master
  import ahb_pkg::*;
#(
  parameter int ADDR_WIDTH = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ERRCNT_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic                    cmd_size,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  output logic [ADDR_WIDTH-1:0]   haddr,
  output logic [1:0]              htrans,
  output logic                    hwrite,
  output logic                    hsize,
  output logic                    hsel,
  output logic [DATA_WIDTH-1:0]   hwdata,
  input  logic [DATA_WIDTH-1:0]   hrdata,
  input  logic                    hresp,
  input  logic                    hready,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_error,
  output logic                    busy,
  output logic [ERRCNT_WIDTH-1:0] err_count
);
  logic a_valid, a_write, a_size;
  logic [ADDR_WIDTH-1:0] a_addr;
  logic [DATA_WIDTH-1:0] a_wdata;
  logic d_valid, d_write, d_size, d_addr0;
  logic [DATA_WIDTH-1:0] d_wdata, wr_lanes, rd_lanes;
  logic accept, retire;
  assign cmd_ready = !a_valid || hready;
  assign accept = cmd_valid && cmd_ready;
  assign retire = d_valid && hready;
  assign busy = a_valid || d_valid;
  ahb_lane_steer #(.EXTRACT(1'b0)) u_wr (.size(d_size), .addr0(d_addr0), .din(d_wdata), .dout(wr_lanes));
  ahb_lane_steer #(.EXTRACT(1'b1)) u_rd (.size(d_size), .addr0(d_addr0), .din(hrdata), .dout(rd_lanes));
  // bus outputs come straight from the stage registers, so a stall freezes them
  always_comb begin
    htrans = a_valid ? HTRANS_NONSEQ : HTRANS_IDLE;
    hsel = a_valid;
    haddr = a_valid ? a_addr : '0;
    hwrite = a_valid && a_write;
    hsize = a_valid ? a_size : HSIZE_BYTE;
    hwdata = d_valid && d_write ? wr_lanes : '0;
  end
  // address stage: loads on accept, empties once its transfer moves to the data stage
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      a_valid <= 1'b0;
      a_write <= 1'b0;
      a_size <= 1'b0;
      a_addr <= '0;
      a_wdata <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_write <= cmd_write;
      a_size <= cmd_size;
      a_addr <= cmd_addr;
      a_wdata <= cmd_wdata;
    end else if (hready) a_valid <= 1'b0;
  // data stage: takes whatever the address stage held on every non-stalled edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      d_valid <= 1'b0;
      d_write <= 1'b0;
      d_size <= 1'b0;
      d_addr0 <= 1'b0;
      d_wdata <= '0;
    end else if (hready) begin
      d_valid <= a_valid;
      d_write <= a_write;
      d_size <= a_size;
      d_addr0 <= a_addr[0];
      d_wdata <= a_wdata;
    end
  // response and saturating error count, registered on the retire edge
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_error <= 1'b0;
      rsp_rdata <= '0;
      err_count <= '0;
    end else if (retire) begin
      rsp_valid <= 1'b1;
      rsp_error <= hresp;
      rsp_rdata <= d_write ? '0 : rd_lanes;
      if (hresp == HRESP_ERROR && err_count != '1) err_count <= err_count + 1'b1;
    end else rsp_valid <= 1'b0;
endmodule

// File: tb/tb_ahb_lite_master.sv
// tb_ahb_lite_master: directed scenarios plus a randomized stream against a memory model
module tb_ahb_lite_master;
  import ahb_pkg::*;
  typedef struct packed {logic [15:0] rdata; logic err;} rsp_t;
  logic clk = 1'b0, rst = 1'b1;
  logic cmd_valid, cmd_ready, cmd_write, cmd_size;
  logic [3:0] cmd_addr, haddr;
  logic [15:0] cmd_wdata, hwdata, hrdata, rsp_rdata;
  logic [1:0] htrans;
  logic hwrite, hsize, hsel, hresp, hready, rsp_valid, rsp_error, busy;
  logic [7:0] err_count;
  int vectors = 0, miscompares = 0, err_total = 0;
  logic [15:0] mem [8];
  logic [7:0] ref_mem [16];
  rsp_t exp_q[$];
  logic sv_valid, sv_write, sv_size, ovr_en = 1'b0, err_all = 1'b0;
  logic [3:0] sv_addr;
  logic [15:0] ovr_val = 16'h0;
  ahb_lite_master dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_size(cmd_size), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .haddr(haddr), .htrans(htrans),
    .hwrite(hwrite), .hsize(hsize), .hsel(hsel), .hwdata(hwdata), .hrdata(hrdata), .hresp(hresp),
    .hready(hready), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_error(rsp_error),
    .busy(busy), .err_count(err_count)
  );
  always #5 clk = ~clk;
  // slave: 8-word memory with AHB address/data phase timing; errors on address F or when forced
  always @(posedge clk or posedge rst)
    if (rst) begin
      sv_valid <= 1'b0;
      for (int i = 0; i < 8; i++) mem[i] <= 16'(32'h1111 * i);
    end else if (hready) begin
      if (sv_valid && sv_write) begin
        if (sv_size) mem[sv_addr[3:1]] <= hwdata;
        else if (sv_addr[0]) mem[sv_addr[3:1]][15:8] <= hwdata[15:8];
        else mem[sv_addr[3:1]][7:0] <= hwdata[7:0];
      end
      sv_valid <= hsel && htrans == HTRANS_NONSEQ;
      sv_write <= hwrite;
      sv_size <= hsize;
      sv_addr <= haddr;
    end
  assign hrdata = ovr_en ? ovr_val : (sv_valid && !sv_write) ? mem[sv_addr[3:1]] : 16'hDEAD;
  assign hresp = sv_valid && (err_all || sv_addr == 4'hF);
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  task automatic drive(input logic v, input logic w, input logic sz, input logic [3:0] a, input logic [15:0] d);
    cmd_valid = v;
    cmd_write = w;
    cmd_size = sz;
    cmd_addr = a;
    cmd_wdata = d;
  endtask
  function automatic void model_cmd(input logic w, input logic sz, input logic [3:0] a, input logic [15:0] d);
    logic [3:0] lo, hi;
    rsp_t r;
    lo = {a[3:1], 1'b0};
    hi = {a[3:1], 1'b1};
    r.err = err_all || a == 4'hF;
    r.rdata = 16'h0;
    if (w && sz) begin
      ref_mem[lo] = d[7:0];
      ref_mem[hi] = d[15:8];
    end else if (w) ref_mem[a] = d[7:0];
    else r.rdata = sz ? {ref_mem[hi], ref_mem[lo]} : {8'h00, ref_mem[a]};
    if (r.err) err_total++;
    exp_q.push_back(r);
  endfunction
  task automatic do_reset;
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 0, 4'h0, 16'h0);
    hready = 1'b1;
    ovr_en = 1'b0;
    err_all = 1'b0;
    exp_q.delete();
    err_total = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 8'(17 * (i >> 1));
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic test_reset;
    do_reset();
    #1;
    vectors++;
    if ({htrans, hsel, haddr, hwrite, hsize, hwdata} !== 25'h0) begin
      miscompares++;
      $display("FAIL reset_bus: got %h expected 0", {htrans, hsel, haddr, hwrite, hsize, hwdata});
    end
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_error, err_count, busy, cmd_ready} !== {27'h0, 1'b1}) begin
      miscompares++;
      $display("FAIL reset_rsp: got %h expected %h", {rsp_valid, rsp_rdata, rsp_error, err_count, busy, cmd_ready}, {27'h0, 1'b1});
    end
  endtask
  task automatic test_halfword_write;
    do_reset();
    drive(1, 1, 1, 4'h4, 16'hBEEF);
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if ({htrans, hsel, haddr, hwrite, hsize, hwdata} !== {HTRANS_NONSEQ, 1'b1, 4'h4, 1'b1, 1'b1, 16'h0}) begin
      miscompares++;
      $display("FAIL hw_addr_phase: got %h expected %h", {htrans, hsel, haddr, hwrite, hsize, hwdata}, {HTRANS_NONSEQ, 1'b1, 4'h4, 1'b1, 1'b1, 16'h0});
    end
    @(negedge clk);
    vectors++;
    if ({htrans, hsel, hwdata, rsp_valid} !== {HTRANS_IDLE, 1'b0, 16'hBEEF, 1'b0}) begin
      miscompares++;
      $display("FAIL hw_data_phase: got %h expected %h", {htrans, hsel, hwdata, rsp_valid}, {HTRANS_IDLE, 1'b0, 16'hBEEF, 1'b0});
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_error, rsp_rdata, busy} !== {1'b1, 1'b0, 16'h0, 1'b0}) begin
      miscompares++;
      $display("FAIL hw_rsp: got %h expected %h", {rsp_valid, rsp_error, rsp_rdata, busy}, {1'b1, 1'b0, 16'h0, 1'b0});
    end
    @(negedge clk);
    vectors++;
    if (rsp_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hw_rsp_pulse: got %b expected 0", rsp_valid);
    end
  endtask
  task automatic test_byte_lanes;
    logic tw [4] = '{1'b1, 1'b1, 1'b0, 1'b0};
    logic [3:0] ta [4] = '{4'h7, 4'h6, 4'h7, 4'h6};
    logic [15:0] td [4] = '{16'h00A5, 16'h12C3, 16'h3C00, 16'h3C5A};
    logic [15:0] te [4] = '{16'hA500, 16'h00C3, 16'h003C, 16'h005A};
    do_reset();
    for (int i = 0; i < 4; i++) begin
      ovr_en = !tw[i];
      ovr_val = td[i];
      drive(1, tw[i], 0, ta[i], tw[i] ? td[i] : 16'h0);
      @(negedge clk);
      cmd_valid = 1'b0;
      @(negedge clk);
      vectors++;
      if (hwdata !== (tw[i] ? te[i] : 16'h0)) begin
        miscompares++;
        $display("FAIL byte_hwdata[%0d]: got %h expected %h", i, hwdata, tw[i] ? te[i] : 16'h0);
      end
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata} !== {1'b1, tw[i] ? 16'h0 : te[i]}) begin
        miscompares++;
        $display("FAIL byte_rsp[%0d]: got %h expected %h", i, {rsp_valid, rsp_rdata}, {1'b1, tw[i] ? 16'h0 : te[i]});
      end
      @(negedge clk);
      vectors++;
      if ({rsp_valid, rsp_rdata} !== {1'b0, tw[i] ? 16'h0 : te[i]}) begin
        miscompares++;
        $display("FAIL byte_rsp_hold[%0d]: got %h expected %h", i, {rsp_valid, rsp_rdata}, {1'b0, tw[i] ? 16'h0 : te[i]});
      end
    end
    ovr_en = 1'b0;
  endtask
  task automatic test_back_to_back;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      if (i < 4) begin
        drive(1, 0, 1, 4'(6 + 2 * i), 16'h0);
        #1;
        vectors++;
        if (cmd_ready !== 1'b1) begin
          miscompares++;
          $display("FAIL b2b_ready[%0d]: got %b expected 1", i, cmd_ready);
        end
      end else cmd_valid = 1'b0;
      @(negedge clk);
      if (i < 4) begin
        vectors++;
        if ({htrans, haddr} !== {HTRANS_NONSEQ, 4'(6 + 2 * i)}) begin
          miscompares++;
          $display("FAIL b2b_addr[%0d]: got %h expected %h", i, {htrans, haddr}, {HTRANS_NONSEQ, 4'(6 + 2 * i)});
        end
      end
      if (i >= 2) begin
        vectors++;
        if (i < 6 && {rsp_valid, rsp_rdata} !== {1'b1, 16'(32'h1111 * (i + 1))}) begin
          miscompares++;
          $display("FAIL b2b_rsp[%0d]: got %h expected %h", i - 2, {rsp_valid, rsp_rdata}, {1'b1, 16'(32'h1111 * (i + 1))});
        end
        if (i == 6 && {rsp_valid, busy} !== 2'b00) begin
          miscompares++;
          $display("FAIL b2b_end: got %b expected 00", {rsp_valid, busy});
        end
      end
    end
  endtask
  task automatic test_stall;
    do_reset();
    drive(1, 1, 1, 4'h2, 16'h1234);
    @(negedge clk);
    drive(1, 0, 1, 4'h2, 16'h0);
    @(negedge clk);
    drive(1, 0, 1, 4'h4, 16'h0);
    hready = 1'b0;
    #1;
    vectors++;
    if ({cmd_ready, rsp_valid} !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_ready: got %b expected 00", {cmd_ready, rsp_valid});
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      vectors++;
      if ({htrans, haddr, hwdata, cmd_ready, rsp_valid, busy} !== {HTRANS_NONSEQ, 4'h2, 16'h1234, 3'b001}) begin
        miscompares++;
        $display("FAIL stall_frozen[%0d]: got %h expected %h", k, {htrans, haddr, hwdata, cmd_ready, rsp_valid, busy}, {HTRANS_NONSEQ, 4'h2, 16'h1234, 3'b001});
      end
    end
    hready = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    vectors++;
    if ({rsp_valid, rsp_rdata, htrans, haddr, hwdata} !== {1'b1, 16'h0, HTRANS_NONSEQ, 4'h4, 16'h0}) begin
      miscompares++;
      $display("FAIL stall_release: got %h expected %h", {rsp_valid, rsp_rdata, htrans, haddr, hwdata}, {1'b1, 16'h0, HTRANS_NONSEQ, 4'h4, 16'h0});
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h1234}) begin
      miscompares++;
      $display("FAIL stall_rsp1: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 16'h1234});
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_rdata} !== {1'b1, 16'h2222}) begin
      miscompares++;
      $display("FAIL stall_rsp2: got %h expected %h", {rsp_valid, rsp_rdata}, {1'b1, 16'h2222});
    end
    @(negedge clk);
    vectors++;
    if ({rsp_valid, busy} !== 2'b00) begin
      miscompares++;
      $display("FAIL stall_end: got %b expected 00", {rsp_valid, busy});
    end
  endtask
  task automatic test_error;
    logic [7:0] want [3] = '{8'hFE, 8'hFF, 8'hFF};
    int bursts [3] = '{253, 1, 10};
    do_reset();
    err_all = 1'b1;
    drive(1, 1, 1, 4'h0, 16'h5555);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_error, err_count} !== {2'b11, 8'h01}) begin
      miscompares++;
      $display("FAIL err_first: got %h expected %h", {rsp_valid, rsp_error, err_count}, {2'b11, 8'h01});
    end
    for (int b = 0; b < 3; b++) begin
      cmd_valid = 1'b1;
      repeat (bursts[b]) @(negedge clk);
      cmd_valid = 1'b0;
      repeat (3) @(negedge clk);
      vectors++;
      if ({err_count, busy} !== {want[b], 1'b0}) begin
        miscompares++;
        $display("FAIL err_count[%0d]: got %h expected %h", b, {err_count, busy}, {want[b], 1'b0});
      end
    end
    err_all = 1'b0;
    cmd_valid = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_error, err_count} !== {2'b10, 8'hFF}) begin
      miscompares++;
      $display("FAIL err_okay: got %h expected %h", {rsp_valid, rsp_error, err_count}, {2'b10, 8'hFF});
    end
  endtask
  task automatic test_reset_midflight;
    do_reset();
    drive(1, 1, 1, 4'h8, 16'hCAFE);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (hwdata !== 16'hCAFE) begin
      miscompares++;
      $display("FAIL mid_data_phase: got %h expected cafe", hwdata);
    end
    rst = 1'b1;
    #1;
    vectors++;
    if ({htrans, hsel, busy, rsp_valid, hwdata} !== 21'h0) begin
      miscompares++;
      $display("FAIL mid_reset: got %h expected 0", {htrans, hsel, busy, rsp_valid, hwdata});
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      vectors++;
      if ({rsp_valid, busy} !== 2'b00) begin
        miscompares++;
        $display("FAIL mid_no_rsp[%0d]: got %b expected 00", k, {rsp_valid, busy});
      end
    end
    drive(1, 0, 1, 4'h8, 16'h0);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    vectors++;
    if ({rsp_valid, rsp_rdata, rsp_error} !== {1'b1, 16'h4444, 1'b0}) begin
      miscompares++;
      $display("FAIL mid_recover: got %h expected %h", {rsp_valid, rsp_rdata, rsp_error}, {1'b1, 16'h4444, 1'b0});
    end
  endtask
  task automatic test_random;
    logic pend = 1'b0, w = 1'b0, sz = 1'b0;
    logic [3:0] a = 4'h0;
    logic [15:0] d = 16'h0;
    rsp_t e;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      if (!pend && c < 560 && $urandom_range(0, 3) != 0) begin
        pend = 1'b1;
        w = 1'($urandom_range(0, 1));
        sz = 1'($urandom_range(0, 1));
        a = 4'($urandom);
        d = 16'($urandom);
      end
      drive(pend, w, sz, a, d);
      hready = c >= 560 || $urandom_range(0, 3) != 0;
      #1;
      if (cmd_valid && cmd_ready) begin
        model_cmd(w, sz, a, d);
        pend = 1'b0;
      end
      @(negedge clk);
      if (rsp_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL rnd_extra_rsp: got rsp_valid=1 expected no response at cycle %0d", c);
        end else begin
          e = exp_q.pop_front();
          if ({rsp_rdata, rsp_error} !== e) begin
            miscompares++;
            $display("FAIL rnd_rsp: got rdata=%h err=%b expected rdata=%h err=%b", rsp_rdata, rsp_error, e.rdata, e.err);
          end
        end
      end
      vectors++;
      if (busy !== (exp_q.size() != 0) || hsel !== (htrans == HTRANS_NONSEQ)) begin
        miscompares++;
        $display("FAIL rnd_status: got busy=%b hsel=%b expected busy=%b hsel=%b", busy, hsel, exp_q.size() != 0, htrans == HTRANS_NONSEQ);
      end
    end
    cmd_valid = 1'b0;
    vectors++;
    if (exp_q.size() != 0 || err_count !== (err_total > 255 ? 8'hFF : 8'(err_total))) begin
      miscompares++;
      $display("FAIL rnd_drain: got pending=%0d err_count=%h expected pending=0 err_count=%h", exp_q.size(), err_count, err_total > 255 ? 8'hFF : 8'(err_total));
    end
  endtask
  initial begin
    drive(0, 0, 0, 4'h0, 16'h0);
    hready = 1'b1;
    test_reset();
    test_halfword_write();
    test_byte_lanes();
    test_back_to_back();
    test_stall();
    test_error();
    test_reset_midflight();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/ahb_lite_master.md
Name: ahb_lite_master

Overview:
Single-transfer AHB-Lite initiator that converts a valid/ready command stream into pipelined NONSEQ transfers and returns one response per command. It sits between test/control logic and the FIR coefficient/sample register slave, driving that slave's haddr/htrans/hwrite/hsize/hwdata/hsel inputs and consuming its hrdata/hresp. Address and data phases overlap, so back-to-back commands sustain one transfer per cycle when hready is high. Byte-lane steering for 8-bit accesses is handled locally.

Parameters:
ADDR_WIDTH, 4, width of haddr and cmd_addr
DATA_WIDTH, 16, bus width; fixed at 16, because lane steering assumes two byte lanes
ERRCNT_WIDTH, 8, width of the saturating error counter

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-high reset
cmd_valid  in  1  command offered
cmd_ready  out  1  command accepted on the edge where cmd_valid&&cmd_ready
cmd_write  in  1  1=write, 0=read
cmd_size  in  1  0=byte, 1=halfword
cmd_addr  in  ADDR_WIDTH  byte address
cmd_wdata  in  16  write data, right-justified for byte writes
haddr  out  ADDR_WIDTH  AHB address
htrans  out  2  IDLE 2'b00 / NONSEQ 2'b10
hwrite  out  1  AHB write
hsize  out  1  0=byte, 1=halfword
hsel  out  1  slave select, equal to (htrans==NONSEQ)
hwdata  out  16  write data, driven during the data phase
hrdata  in  16  read data
hresp  in  1  1=error, sampled at data-phase completion
hready  in  1  transfer-phase advance; tie high for a zero-wait slave
rsp_valid  out  1  one-cycle response pulse
rsp_rdata  out  16  read data, right-justified for byte reads; 0 for writes
rsp_error  out  1  hresp captured for this transfer
busy  out  1  address or data stage occupied
err_count  out  ERRCNT_WIDTH  saturating count of error responses

Behaviour:
- Two pipeline stages, each a valid bit plus registered fields:
  - A (address phase): addr, size, write, wdata.
  - D (data phase): addr[0], size, write, wdata.
- Stage occupancy forms the state: IDLE (A=0,D=0), ADDR (A=1,D=0), PIPE (A=1,D=1), DATA (A=0,D=1).
- cmd_ready = !A_valid || hready (combinational). The command loads into A on the accepting edge.
- Outputs while A_valid=1: htrans=NONSEQ, hsel=1, haddr/hwrite/hsize from A.
- Outputs while A_valid=0: htrans=IDLE, hsel=0, haddr/hwrite/hsize=0.
- Stage advance:
  - A→D on an edge with A_valid&&hready.
  - D retires on an edge with D_valid&&hready.
  - Both advances happen on the same edge when both stages are occupied.
  - hready=0 freezes A, D and all bus outputs.
- hwdata is driven from D while D_valid&&D_write, otherwise 0. Byte write steering:
  - D_addr0=0 → {8'h00, wdata[7:0]}.
  - D_addr0=1 → {wdata[7:0], 8'h00}.
  - Halfword write → wdata unchanged.
- Retire edge registers the response:
  - rsp_valid=1 for exactly one cycle.
  - rsp_error=hresp.
  - rsp_rdata for a read: halfword → hrdata; byte → {8'h00, hrdata[15:8]} if addr0=1, else {8'h00, hrdata[7:0]}.
  - rsp_rdata for a write: 0.
  - When there is no retire, rsp_valid=0; rsp_rdata and rsp_error hold their last values.
- Latency with hready=1: command accepted at edge N → NONSEQ in cycle N..N+1, data phase cycle N+1..N+2, rsp_valid high cycle N+2..N+3. Responses are returned strictly in order.
- An error does not cancel an already-issued address phase.
- err_count increments on each retire with hresp=1 and saturates at all-ones.
- Halfword access with addr[0]=1 is issued unchanged; there is no local alignment check.
- Reset values:
  - A_valid=0, D_valid=0; htrans=IDLE, hsel=0, haddr=0, hwrite=0, hsize=0, hwdata=0.
  - rsp_valid=0, rsp_rdata=0, rsp_error=0, err_count=0, busy=0.
- Reset asserted mid-transfer drops all in-flight transfers with no response.
- busy = A_valid || D_valid.

Decomposition:
- Shared package ahb_pkg holds: HTRANS_IDLE=2'b00, HTRANS_NONSEQ=2'b10, HSIZE_BYTE=1'b0, HSIZE_HALF=1'b1, HRESP_OKAY=1'b0, HRESP_ERROR=1'b1, and an enum for the four occupancy states (debug/assertions only).
- One combinational sub-module, ahb_lane_steer, implements write steering and read extraction from (size, addr0); it is instantiated once for each direction.

Test Plan:
1. Reset, then halfword write cmd_addr=4'h4, cmd_wdata=16'hBEEF with hready=1 → NONSEQ haddr=4 hwrite=1 for one cycle, then hwdata=16'hBEEF, then rsp_valid=1, rsp_error=0.
2. Byte write cmd_addr=4'h7, cmd_wdata=16'h00A5 → hwdata=16'hA500; byte read addr 4'h7 with hrdata=16'h3C00 → rsp_rdata=16'h003C.
3. Four back-to-back reads at addresses 6, 8, A, C with hready=1 → htrans=NONSEQ for four consecutive cycles, cmd_ready stays 1, four consecutive rsp_valid pulses in order.
4. Hold hready=0 for 3 cycles during PIPE → haddr, htrans, hwdata and cmd_ready=0 frozen; on release both stages advance, with exactly one rsp_valid per command.
5. Write to addr 4'h0 with hresp=1 at completion → rsp_error=1, err_count 0→1; 255 further errors → err_count remains 8'hFF.
6. Assert rst during a data phase → htrans=IDLE, hsel=0, busy=0 and no rsp_valid; a subsequent command completes normally.
